// File: rtl/shooter_pkg.sv
// Shared shooter definitions: sequencer state encoding, default duty constants
// and the bounded duty slew helper.
package shooter_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ARMING = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int unsigned DUTY_MIN_DEFAULT  = 40000;
    localparam int unsigned DUTY_MAX_DEFAULT  = 100000;
    localparam int unsigned DUTY_INIT_DEFAULT = 50000;
    localparam int unsigned DUTY_STEP_DEFAULT = 5000;
    localparam int unsigned RAMP_STEP_DEFAULT = 1000;

    // Move cur toward tgt by at most step; differences are taken before any add
    // or subtract so nothing wraps.
    function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                                input logic [31:0] tgt,
                                                input logic [31:0] step);
        logic [31:0] next;
        next = cur;
        if (cur < tgt)
            next = (tgt - cur > step) ? cur + step : tgt;
        else if (cur > tgt)
            next = (cur - tgt > step) ? cur - step : tgt;
        return next;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stable-level debounce counter and a one-cycle pulse
// on each debounced rising edge.
module button_debouncer #(
    parameter int unsigned DEBOUNCE = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            count <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            // Count consecutive cycles where the synchronized input disagrees
            // with the debounced level; any agreement restarts the count.
            if (sync2 == level) begin
                count <= '0;
            end else if (count == LAST) begin
                count <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shooter_speed_sequencer.sv
// Shooter ESC sequencer: operator target from debounced buttons, arming phase,
// and period-aligned slewing of the PWM duty word toward the target.
module shooter_speed_sequencer
    import shooter_pkg::*;
#(
    parameter int unsigned DUTY_MIN     = DUTY_MIN_DEFAULT,
    parameter int unsigned DUTY_MAX     = DUTY_MAX_DEFAULT,
    parameter int unsigned DUTY_INIT    = DUTY_INIT_DEFAULT,
    parameter int unsigned DUTY_STEP    = DUTY_STEP_DEFAULT,
    parameter int unsigned RAMP_STEP    = RAMP_STEP_DEFAULT,
    parameter int unsigned RAMP_PERIODS = 4,
    parameter int unsigned ARM_PERIODS  = 250,
    parameter int unsigned DEBOUNCE     = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        up,
    input  logic        down,
    input  logic        period_start,
    output logic [31:0] duty_cycle,
    output logic [31:0] target,
    output logic [1:0]  state,
    output logic        at_speed
);

    localparam logic [31:0] MIN_W       = 32'(DUTY_MIN);
    localparam logic [31:0] MAX_W       = 32'(DUTY_MAX);
    localparam logic [31:0] INIT_W      = 32'(DUTY_INIT);
    localparam logic [31:0] STEP_W      = 32'(DUTY_STEP);
    localparam logic [31:0] RAMP_W      = 32'(RAMP_STEP);
    localparam logic [31:0] ARM_LAST    = 32'(ARM_PERIODS - 1);
    localparam logic [31:0] RAMP_LAST   = 32'(RAMP_PERIODS - 1);

    state_t      st;
    logic [31:0] arm_count;
    logic [31:0] ramp_count;
    logic        up_press;
    logic        down_press;

    button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_up_debouncer (
        .clock (clock),
        .reset (reset),
        .raw   (up),
        .press (up_press)
    );

    button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_down_debouncer (
        .clock (clock),
        .reset (reset),
        .raw   (down),
        .press (down_press)
    );

    assign state = st;

    // Target stays within [DUTY_MIN, DUTY_MAX]; headroom is checked before stepping.
    always_ff @(posedge clock) begin
        if (reset) begin
            target <= INIT_W;
        end else if (up_press && !down_press) begin
            target <= (MAX_W - target < STEP_W) ? MAX_W : target + STEP_W;
        end else if (down_press && !up_press) begin
            target <= (target - MIN_W < STEP_W) ? MIN_W : target - STEP_W;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st         <= ST_OFF;
            duty_cycle <= MIN_W;
            arm_count  <= '0;
            ramp_count <= '0;
            at_speed   <= 1'b0;
        end else begin
            at_speed <= (st == ST_RUN) && (duty_cycle == target);
            if (!enable) begin
                st         <= ST_OFF;
                duty_cycle <= MIN_W;
                arm_count  <= '0;
                ramp_count <= '0;
            end else begin
                case (st)
                    ST_OFF: begin
                        st         <= ST_ARMING;
                        duty_cycle <= MIN_W;
                        arm_count  <= '0;
                    end
                    ST_ARMING: begin
                        duty_cycle <= MIN_W;
                        if (period_start) begin
                            if (arm_count == ARM_LAST) begin
                                st         <= ST_RUN;
                                arm_count  <= '0;
                                ramp_count <= '0;
                            end else begin
                                arm_count <= arm_count + 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (period_start) begin
                            if (ramp_count == RAMP_LAST) begin
                                ramp_count <= '0;
                                duty_cycle <= step_toward(duty_cycle, target, RAMP_W);
                            end else begin
                                ramp_count <= ramp_count + 1'b1;
                            end
                        end
                    end
                    default: begin
                        st         <= ST_OFF;
                        duty_cycle <= MIN_W;
                    end
                endcase
            end
        end
    end

endmodule
